wb_arbiter: RTL

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// ============================================================================
// wb_arbiter : two-source register-file writeback arbiter with per-source
//              FIFOs and round-robin grant; one registered write per cycle.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module wb_arbiter #(
  parameter int DW    = 16,
  parameter int AW    = 3,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       a_valid,
  output logic                       a_ready,
  input  logic [AW-1:0]              a_wreg,
  input  logic [DW-1:0]              a_wd,
  input  logic                       b_valid,
  output logic                       b_ready,
  input  logic [AW-1:0]              b_wreg,
  input  logic [DW-1:0]              b_wd,
  input  logic                       flush,
  output logic                       wr_en,
  output logic [AW-1:0]              wr_reg,
  output logic [DW-1:0]              wr_data,
  output logic [$clog2(DEPTH):0]     a_count,
  output logic [$clog2(DEPTH):0]     b_count,
  output logic                       busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = AW + DW;

  typedef enum logic {SRC_A = 1'b0, SRC_B = 1'b1} src_e;

  logic [EW-1:0] a_mem [DEPTH];
  logic [EW-1:0] b_mem [DEPTH];

  logic [PW-1:0] a_rd_q, a_rd_d, a_wr_q, a_wr_d;
  logic [PW-1:0] b_rd_q, b_rd_d, b_wr_q, b_wr_d;
  logic [CW-1:0] a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
  src_e          last_grant_q, last_grant_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_reg_q, wr_reg_d;
  logic [DW-1:0] wr_data_q, wr_data_d;

  logic          a_push, b_push, a_ne, b_ne, grant_a, grant_b;
  logic [EW-1:0] a_head, b_head;

  assign a_ready = (a_cnt_q < CW'(DEPTH)) && !flush;
  assign b_ready = (b_cnt_q < CW'(DEPTH)) && !flush;
  assign a_push  = a_valid && a_ready;
  assign b_push  = b_valid && b_ready;
  assign a_ne    = (a_cnt_q != '0);
  assign b_ne    = (b_cnt_q != '0);
  assign a_head  = a_mem[a_rd_q];
  assign b_head  = b_mem[b_rd_q];

  // On a tie the source that did not win last time takes the grant.
  assign grant_a = !flush && a_ne && (!b_ne || (last_grant_q == SRC_B));
  assign grant_b = !flush && b_ne && !grant_a;

  always_comb begin
    a_rd_d       = a_rd_q;
    a_wr_d       = a_wr_q;
    b_rd_d       = b_rd_q;
    b_wr_d       = b_wr_q;
    a_cnt_d      = a_cnt_q;
    b_cnt_d      = b_cnt_q;
    last_grant_d = last_grant_q;
    wr_en_d      = 1'b0;
    wr_reg_d     = wr_reg_q;
    wr_data_d    = wr_data_q;
    if (flush) begin
      a_rd_d  = '0;
      a_wr_d  = '0;
      b_rd_d  = '0;
      b_wr_d  = '0;
      a_cnt_d = '0;
      b_cnt_d = '0;
    end else begin
      if (a_push) a_wr_d = a_wr_q + PW'(1);
      if (b_push) b_wr_d = b_wr_q + PW'(1);
      if (grant_a) a_rd_d = a_rd_q + PW'(1);
      if (grant_b) b_rd_d = b_rd_q + PW'(1);
      a_cnt_d = a_cnt_q + CW'(a_push) - CW'(grant_a);
      b_cnt_d = b_cnt_q + CW'(b_push) - CW'(grant_b);
      if (grant_a) begin
        wr_en_d      = 1'b1;
        {wr_reg_d, wr_data_d} = a_head;
        last_grant_d = SRC_A;
      end else if (grant_b) begin
        wr_en_d      = 1'b1;
        {wr_reg_d, wr_data_d} = b_head;
        last_grant_d = SRC_B;
      end
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (a_push) a_mem[a_wr_q] <= {a_wreg, a_wd};
    if (b_push) b_mem[b_wr_q] <= {b_wreg, b_wd};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_rd_q       <= '0;
      a_wr_q       <= '0;
      b_rd_q       <= '0;
      b_wr_q       <= '0;
      a_cnt_q      <= '0;
      b_cnt_q      <= '0;
      last_grant_q <= SRC_B;
      wr_en_q      <= 1'b0;
      wr_reg_q     <= '0;
      wr_data_q    <= '0;
    end else begin
      a_rd_q       <= a_rd_d;
      a_wr_q       <= a_wr_d;
      b_rd_q       <= b_rd_d;
      b_wr_q       <= b_wr_d;
      a_cnt_q      <= a_cnt_d;
      b_cnt_q      <= b_cnt_d;
      last_grant_q <= last_grant_d;
      wr_en_q      <= wr_en_d;
      wr_reg_q     <= wr_reg_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_reg  = wr_reg_q;
  assign wr_data = wr_data_q;
  assign a_count = a_cnt_q;
  assign b_count = b_cnt_q;
  assign busy    = a_ne || b_ne || wr_en_q;

endmodule

`default_nettype wire
